// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the ram_dma block-copy/fill sequencer.
package ram_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    FIN
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/ram_dma_addr_gen.sv
// Source/destination word pointers and remaining-word counter for ram_dma.
// Pointers wrap modulo 2**ADDR_W; last flags the final word of the command.
module ram_dma_addr_gen #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_init,
  input  logic [ADDR_W-1:0] dst_init,
  input  logic [ADDR_W:0]   len_init,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic [ADDR_W-1:0] src_next,
  output logic [ADDR_W-1:0] dst_next,
  output logic              last
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W:0]   remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
    end else if (load) begin
      src_ptr   <= src_init;
      dst_ptr   <= dst_init;
      remaining <= len_init;
    end else if (step) begin
      src_ptr   <= src_next;
      dst_ptr   <= dst_next;
      remaining <= remaining - CNT_ONE;
    end
  end

  // Natural overflow of the ADDR_W-bit add gives the 31 -> 0 wrap.
  assign src_next = src_ptr + PTR_ONE;
  assign dst_next = dst_ptr + PTR_ONE;
  assign last     = (remaining == CNT_ONE);

endmodule

// File: rtl/ram_dma.sv
// Block copy/fill sequencer driving a single-port synchronous RAM.
// Optional RAM_DMA_CHECKSUM_EN adds an XOR checksum of all words written.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_t            state;
  logic              mode_q;
  logic [1:0]        wait_cnt;
  logic              load;
  logic              step;
  logic              wait_last;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0] src_next;
  logic [ADDR_W-1:0] dst_next;
  logic              last;

  assign load      = (state == IDLE) && start;
  assign step      = (state == WR);
  assign wait_last = (state == WAIT) && (wait_cnt == 2'd0);

  ram_dma_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .src_init (src_addr),
    .dst_init (dst_addr),
    .len_init (len),
    .dst_ptr  (dst_ptr),
    .src_next (src_next),
    .dst_next (dst_next),
    .last     (last)
  );

  // Outputs are registered: each transition loads the bus values of the
  // state being entered. ram_wdata doubles as the read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= MODE_COPY;
      wait_cnt  <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_ena   <= 1'b0;
      ram_wena  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      done     <= 1'b0;
      ram_ena  <= 1'b0;
      ram_wena <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            if (len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (mode == MODE_FILL) begin
              state     <= WR;
              busy      <= 1'b1;
              ram_ena   <= 1'b1;
              ram_wena  <= 1'b1;
              ram_addr  <= dst_addr;
              ram_wdata <= fill_data;
            end else begin
              state    <= RD;
              busy     <= 1'b1;
              ram_ena  <= 1'b1;
              ram_addr <= src_addr;
            end
          end
        end
        RD: begin
          state    <= WAIT;
          wait_cnt <= WAIT_INIT;
        end
        WAIT: begin
          if (wait_last) begin
            state     <= WR;
            ram_ena   <= 1'b1;
            ram_wena  <= 1'b1;
            ram_addr  <= dst_ptr;
            ram_wdata <= ram_rdata;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        WR: begin
          if (last) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (mode_q == MODE_FILL) begin
            ram_ena  <= 1'b1;
            ram_wena <= 1'b1;
            ram_addr <= dst_next;
          end else begin
            state    <= RD;
            ram_ena  <= 1'b1;
            ram_addr <= src_next;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_DMA_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  // Accumulate on the same edges that load a write word onto the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (load) begin
      csum_q <= ((mode == MODE_FILL) && (len != '0)) ? fill_data : '0;
    end else if (wait_last) begin
      csum_q <= csum_q ^ ram_rdata;
    end else if (step && !last && (mode_q == MODE_FILL)) begin
      csum_q <= csum_q ^ ram_wdata;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_ram_dma.sv
// Self-checking bench for ram_dma: behavioural RAM plus a word-level reference
// model of copy/fill; define RAM_DMA_CHECKSUM_EN to also check the checksum.
module tb_ram_dma;
  import ram_dma_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int TB_RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] fill_data = '0;
  logic          busy, done, ram_ena, ram_wena;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
`ifdef RAM_DMA_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  ram_dma #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(TB_RD_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .fill_data (fill_data),
    .busy      (busy),
    .done      (done),
    .ram_ena   (ram_ena),
    .ram_wena  (ram_wena),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef RAM_DMA_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  // Synchronous single-port RAM with a bench-side preload port.
  logic [DW-1:0] mem [DEPTH];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_ena) begin
      if (ram_wena) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  // Reference model state and scoreboard queues.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [DW-1:0] exp_csum;
  int            exp_done;

  // Observed activity of the last command.
  int            wr_cyc_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            done_at, busy_cnt, ena_cnt;
  logic          done_next;
  logic [DW-1:0] csum_at_done;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void apply_ref(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                                    input logic [AW:0] l, input logic [DW-1:0] f);
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_csum = '0;
    for (int i = 0; i < int'(l); i++) begin
      a = AW'((int'(d) + i) % DEPTH);
      w = m ? f : ref_mem[AW'((int'(s) + i) % DEPTH)];
      ref_mem[a] = w;
      exp_addr_q.push_back(a);
      exp_data_q.push_back(w);
      exp_csum = exp_csum ^ w;
    end
    exp_done = (l == 0) ? 1 : (m ? int'(l) + 1 : (2 + TB_RD_LAT) * int'(l) + 1);
  endfunction

  task automatic sync_ram();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = AW'(a);
      pre_data = ref_mem[a];
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one command and records bus activity per cycle (cycle 1 follows
  // the accepting edge). poke_at > 0 pulses a spurious start in that cycle.
  task automatic run_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW:0] l, input logic [DW-1:0] f, input int poke_at);
    wr_cyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_at = -1;
    busy_cnt = 0;
    ena_cnt = 0;
    csum_at_done = '0;
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f; start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      start     = (n == poke_at);
      mode      = 1'($urandom);
      src_addr  = AW'($urandom);
      dst_addr  = AW'($urandom);
      len       = (n == poke_at) ? 6'd1 : 6'($urandom_range(0, 32));
      fill_data = $urandom;
      if (ram_ena) ena_cnt++;
      if (busy) busy_cnt++;
      if (ram_ena && ram_wena) begin
        wr_cyc_q.push_back(n);
        wr_addr_q.push_back(ram_addr);
        wr_data_q.push_back(ram_wdata);
      end
      if (done) begin
        done_at = n;
`ifdef RAM_DMA_CHECKSUM_EN
        csum_at_done = checksum;
`endif
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    done_next = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, ram_ena, ram_wena} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, ram_ena, ram_wena});
    end
    n_cmp++;
    if ({ram_addr, ram_wdata} !== '0) begin
      n_err++; $display("FAIL reset_bus: got addr %0d wdata %h expected 0/0", ram_addr, ram_wdata);
    end
`ifdef RAM_DMA_CHECKSUM_EN
    n_cmp++;
    if (checksum !== '0) begin
      n_err++; $display("FAIL reset_csum: got %h expected 0", checksum);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = $urandom;
    sync_ram();
    apply_ref(MODE_FILL, 5'd0, 5'd4, 6'd3, 32'hA5A5_0001);
    run_cmd(MODE_FILL, 5'd0, 5'd4, 6'd3, 32'hA5A5_0001, 0);
    n_cmp++;
    if (done_at !== 4) begin n_err++; $display("FAIL fill_done_cycle: got %0d expected 4", done_at); end
    n_cmp++;
    if (wr_addr_q.size() !== 3) begin
      n_err++; $display("FAIL fill_write_count: got %0d expected 3", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (wr_cyc_q[i] !== i + 1 || wr_addr_q[i] !== AW'(4 + i)) begin
          n_err++; $display("FAIL fill_write_%0d: got cycle %0d addr %0d expected cycle %0d addr %0d",
                            i, wr_cyc_q[i], wr_addr_q[i], i + 1, 4 + i);
        end
      end
    end
    for (int a = 4; a < 7; a++) begin
      n_cmp++;
      if (mem[a] !== 32'hA5A5_0001) begin
        n_err++; $display("FAIL fill_ram_%0d: got %h expected a5a50001", a, mem[a]);
      end
    end
    n_cmp++;
    if (busy_cnt !== 3 || done_next !== 1'b0) begin
      n_err++; $display("FAIL fill_busy_done: got busy %0d done_next %b expected 3/0", busy_cnt, done_next);
    end
  endtask

  task automatic test_copy();
    ref_mem[0] = 32'd11;
    ref_mem[1] = 32'd22;
    sync_ram();
    apply_ref(MODE_COPY, 5'd0, 5'd10, 6'd2, '0);
    run_cmd(MODE_COPY, 5'd0, 5'd10, 6'd2, 32'hDEAD_BEEF, 0);
    n_cmp++;
    if (done_at !== 7) begin n_err++; $display("FAIL copy_done_cycle: got %0d expected 7", done_at); end
    n_cmp++;
    if (wr_cyc_q.size() !== 2 || wr_cyc_q[0] !== 3 || wr_cyc_q[1] !== 6) begin
      n_err++; $display("FAIL copy_write_cycles: got %0d writes expected writes in cycles 3,6", wr_cyc_q.size());
    end
    n_cmp++;
    if (mem[10] !== 32'd11 || mem[11] !== 32'd22) begin
      n_err++; $display("FAIL copy_ram: got %0d,%0d expected 11,22", mem[10], mem[11]);
    end
    n_cmp++;
    if (ena_cnt !== 4) begin n_err++; $display("FAIL copy_ena_cycles: got %0d expected 4", ena_cnt); end
  endtask

  task automatic test_wrap();
    apply_ref(MODE_FILL, 5'd0, 5'd30, 6'd4, 32'h0BAD_F00D);
    run_cmd(MODE_FILL, 5'd0, 5'd30, 6'd4, 32'h0BAD_F00D, 0);
    n_cmp++;
    if (wr_addr_q.size() !== 4) begin
      n_err++; $display("FAIL wrap_count: got %0d expected 4", wr_addr_q.size());
    end else begin
      n_cmp++;
      if (wr_addr_q[0] !== 5'd30 || wr_addr_q[1] !== 5'd31 || wr_addr_q[2] !== 5'd0 || wr_addr_q[3] !== 5'd1) begin
        n_err++; $display("FAIL wrap_order: got %0d,%0d,%0d,%0d expected 30,31,0,1",
                          wr_addr_q[0], wr_addr_q[1], wr_addr_q[2], wr_addr_q[3]);
      end
    end
  endtask

  task automatic test_len0();
    apply_ref(MODE_COPY, 5'd3, 5'd7, 6'd0, '0);
    run_cmd(MODE_COPY, 5'd3, 5'd7, 6'd0, '0, 0);
    n_cmp++;
    if (done_at !== 1) begin n_err++; $display("FAIL len0_done_cycle: got %0d expected 1", done_at); end
    n_cmp++;
    if (ena_cnt !== 0 || busy_cnt !== 0) begin
      n_err++; $display("FAIL len0_activity: got ena %0d busy %0d expected 0/0", ena_cnt, busy_cnt);
    end
  endtask

  task automatic test_busy_start();
    apply_ref(MODE_COPY, 5'd12, 5'd20, 6'd3, '0);
    run_cmd(MODE_COPY, 5'd12, 5'd20, 6'd3, '0, 4);
    n_cmp++;
    if (done_at !== 10) begin n_err++; $display("FAIL busy_start_done: got %0d expected 10", done_at); end
    n_cmp++;
    if (wr_addr_q.size() !== 3) begin
      n_err++; $display("FAIL busy_start_writes: got %0d expected 3", wr_addr_q.size());
    end
    for (int a = 20; a < 23; a++) begin
      n_cmp++;
      if (mem[a] !== ref_mem[a]) begin
        n_err++; $display("FAIL busy_start_ram_%0d: got %h expected %h", a, mem[a], ref_mem[a]);
      end
    end
  endtask

  task automatic test_overlap();
    for (int a = 0; a < 4; a++) ref_mem[a] = DW'(a + 1);
    sync_ram();
    apply_ref(MODE_COPY, 5'd0, 5'd1, 6'd3, '0);
    run_cmd(MODE_COPY, 5'd0, 5'd1, 6'd3, '0, 0);
    for (int a = 0; a < 4; a++) begin
      n_cmp++;
      if (mem[a] !== 32'd1) begin n_err++; $display("FAIL overlap_ram_%0d: got %0d expected 1", a, mem[a]); end
    end
  endtask

  task automatic test_random();
    logic          m;
    logic [AW-1:0] s, d;
    logic [AW:0]   l;
    logic [DW-1:0] f;
    for (int k = 0; k < 12; k++) begin
      m = 1'($urandom);
      s = AW'($urandom);
      d = AW'($urandom);
      l = (k == 0) ? 6'd32 : 6'($urandom_range(0, 32));
      f = $urandom;
      apply_ref(m, s, d, l, f);
      run_cmd(m, s, d, l, f, 0);
      n_cmp++;
      if (done_at !== exp_done) begin
        n_err++; $display("FAIL rand%0d_done: got %0d expected %0d", k, done_at, exp_done);
      end
      n_cmp++;
      if (busy_cnt !== exp_done - 1 || done_next !== 1'b0) begin
        n_err++; $display("FAIL rand%0d_busy: got busy %0d done_next %b expected %0d/0", k, busy_cnt, done_next, exp_done - 1);
      end
      n_cmp++;
      if (wr_addr_q.size() !== exp_addr_q.size()) begin
        n_err++; $display("FAIL rand%0d_count: got %0d expected %0d", k, wr_addr_q.size(), exp_addr_q.size());
      end else begin
        for (int i = 0; i < exp_addr_q.size(); i++) begin
          n_cmp++;
          if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
            n_err++; $display("FAIL rand%0d_wr%0d: got %0d/%h expected %0d/%h", k, i,
                              wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
          end
        end
      end
`ifdef RAM_DMA_CHECKSUM_EN
      n_cmp++;
      if (csum_at_done !== exp_csum) begin
        n_err++; $display("FAIL rand%0d_csum: got %h expected %h", k, csum_at_done, exp_csum);
      end
`endif
    end
    for (int a = 0; a < DEPTH; a++) begin
      n_cmp++;
      if (mem[a] !== ref_mem[a]) begin
        n_err++; $display("FAIL rand_ram_%0d: got %h expected %h", a, mem[a], ref_mem[a]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mode = MODE_COPY; src_addr = 5'd5; dst_addr = 5'd25; len = 6'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, ram_ena, ram_wena} !== 4'b0000 || {ram_addr, ram_wdata} !== '0) begin
      n_err++; $display("FAIL reset_mid_outputs: got ctrl %b addr %0d wdata %h expected all 0",
                        {busy, done, ram_ena, ram_wena}, ram_addr, ram_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ena_cnt = 0;
    busy_cnt = 0;
    done_at = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ram_ena) ena_cnt++;
      if (busy) busy_cnt++;
      if (done) done_at = n;
    end
    n_cmp++;
    if (ena_cnt !== 0 || busy_cnt !== 0 || done_at !== -1) begin
      n_err++; $display("FAIL reset_mid_idle: got ena %0d busy %0d done_at %0d expected 0/0/-1", ena_cnt, busy_cnt, done_at);
    end
    apply_ref(MODE_COPY, 5'd5, 5'd25, 6'd1, '0);
    for (int a = 0; a < DEPTH; a++) begin
      n_cmp++;
      if (mem[a] !== ref_mem[a]) begin
        n_err++; $display("FAIL reset_mid_ram_%0d: got %h expected %h", a, mem[a], ref_mem[a]);
      end
    end
    apply_ref(MODE_FILL, 5'd0, 5'd8, 6'd2, 32'h1234_5678);
    run_cmd(MODE_FILL, 5'd0, 5'd8, 6'd2, 32'h1234_5678, 0);
    n_cmp++;
    if (done_at !== 3) begin n_err++; $display("FAIL reset_mid_resume: got %0d expected 3", done_at); end
  endtask

`ifdef RAM_DMA_CHECKSUM_EN
  task automatic test_checksum();
    apply_ref(MODE_FILL, 5'd0, 5'd14, 6'd2, 32'h0000_00F0);
    run_cmd(MODE_FILL, 5'd0, 5'd14, 6'd2, 32'h0000_00F0, 0);
    n_cmp++;
    if (csum_at_done !== 32'd0) begin
      n_err++; $display("FAIL csum_fill_pair: got %h expected 0", csum_at_done);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (checksum !== 32'd0) begin
      n_err++; $display("FAIL csum_stable: got %h expected 0", checksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_wrap();
    test_len0();
    test_busy_start();
    test_overlap();
    test_random();
    test_reset_mid();
`ifdef RAM_DMA_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
